p601_sysctl: RTL

//  System controller for p601zero-class boards. Generates the CPU clock enable and a legacy 50% sys_clk

---
 rtl/p601_sysctl.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/p601_sysctl.sv
// p601_sysctl: CPU clock enable / sys_clk divider, CPU reset sequencer and masked interrupt aggregator.
// Optional watchdog on register 4 is built only when SYSCTL_WDT_EN is defined.
module p601_sysctl #(
  parameter int OSC_CLOCK  = 12000000,
  parameter int CPU_CLOCK  = 3000000,
  parameter int RES_CYCLES = 4,
  parameter int NIRQ       = 4,
  parameter int WDT_WIDTH  = 16
) (
  input  logic            clk_in,
  input  logic            b_reset,
  output logic            sys_ce,
  output logic            sys_clk,
  output logic            sys_res,
  output logic            sys_irq,
  input  logic [NIRQ-1:0] irq_in,
  input  logic [2:0]      AD,
  input  logic [7:0]      DI,
  output logic [7:0]      DO,
  input  logic            rw,
  input  logic            cs
);

  localparam int DIV = OSC_CLOCK / CPU_CLOCK;
  localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(DIV / 2 - 1);
  localparam logic [7:0]    RES_LOAD = 8'(RES_CYCLES);

  if ((DIV < 2) || ((DIV % 2) != 0)) begin : g_bad_div
    $error("p601_sysctl: OSC_CLOCK/CPU_CLOCK must be even and at least 2");
  end
  if ((NIRQ < 1) || (NIRQ > 8)) begin : g_bad_nirq
    $error("p601_sysctl: NIRQ must be in 1..8");
  end
  if ((RES_CYCLES < 1) || (RES_CYCLES > 255)) begin : g_bad_res
    $error("p601_sysctl: RES_CYCLES must be in 1..255");
  end
  if ((WDT_WIDTH < 1) || (WDT_WIDTH > 32)) begin : g_bad_wdt
    $error("p601_sysctl: WDT_WIDTH must be in 1..32");
  end

  logic [CW-1:0]   cnt;
  logic [7:0]      rcnt;
  logic [NIRQ-1:0] irq_q;
  logic [NIRQ-1:0] pend;
  logic [NIRQ-1:0] pend_nxt;
  logic [NIRQ-1:0] mask;
  logic [NIRQ-1:0] mode;
  logic            wdt_fire;
  logic [7:0]      wdt_rd;
  logic            we;
  logic            we_pend;
  logic            we_mask;
  logic            we_mode;
  logic            unused_di;

  assign unused_di = ^DI;

  assign sys_ce  = (cnt == CNT_LAST);
  assign we      = sys_ce & cs & ~rw & ~sys_res;
  assign we_pend = we && (AD == 3'd0);
  assign we_mask = we && (AD == 3'd1);
  assign we_mode = we && (AD == 3'd2);

  // sys_clk is high for the first half of each CPU cycle, so it rises just after sys_ce.
  always_ff @(posedge clk_in or negedge b_reset) begin
    if (!b_reset) begin
      cnt     <= '0;
      sys_clk <= 1'b0;
    end else begin
      if (cnt == CNT_LAST) begin
        cnt     <= '0;
        sys_clk <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
        if (cnt == CNT_HALF) begin
          sys_clk <= 1'b0;
        end
      end
    end
  end

  // Reset sequencer; a watchdog expiry re-enters the same sequence as a power-on reset.
  always_ff @(posedge clk_in or negedge b_reset) begin
    if (!b_reset) begin
      rcnt    <= RES_LOAD;
      sys_res <= 1'b1;
    end else if (wdt_fire) begin
      rcnt    <= RES_LOAD;
      sys_res <= 1'b1;
    end else if (sys_ce) begin
      if (rcnt != 8'd0) begin
        rcnt <= rcnt - 8'd1;
      end else begin
        sys_res <= 1'b0;
      end
    end
  end

  // Next pending value; a fresh edge always beats a write-1-clear, and leaving level mode drops the level.
  always_comb begin
    pend_nxt = pend;
    for (int i = 0; i < NIRQ; i++) begin
      if (!mode[i]) begin
        pend_nxt[i] = irq_in[i];
      end else begin
        pend_nxt[i] = (irq_in[i] & ~irq_q[i]) | (pend[i] & ~(we_pend & DI[i]));
      end
      if (we_mode && !mode[i] && DI[i]) begin
        pend_nxt[i] = irq_in[i] & ~irq_q[i];
      end
    end
  end

  always_ff @(posedge clk_in or negedge b_reset) begin
    if (!b_reset) begin
      irq_q   <= '0;
      pend    <= '0;
      mask    <= '0;
      mode    <= '0;
      sys_irq <= 1'b0;
    end else if (wdt_fire) begin
      irq_q   <= irq_in;
      pend    <= '0;
      mask    <= '0;
      mode    <= '0;
      sys_irq <= 1'b0;
    end else if (sys_ce) begin
      irq_q   <= irq_in;
      pend    <= pend_nxt;
      sys_irq <= (|(pend & mask)) & ~sys_res;
      if (we_mask) begin
        mask <= DI[NIRQ-1:0];
      end
      if (we_mode) begin
        mode <= DI[NIRQ-1:0];
      end
    end
  end

`ifdef SYSCTL_WDT_EN
  logic [WDT_WIDTH-1:0] wdt_cnt;
  logic                 wdt_en;
  logic                 wdt_fired;
  logic                 wdt_wr;
  logic                 wdt_kick;
  logic                 wdt_tick;

  assign wdt_wr   = we && (AD == 3'd4);
  assign wdt_kick = wdt_wr && (DI == 8'h5A);
  assign wdt_tick = sys_ce & wdt_en & ~sys_res & ~wdt_kick;
  assign wdt_fire = wdt_tick && (wdt_cnt == '0);
  assign wdt_rd   = {wdt_fired, 6'b0, wdt_en};

  // A kick landing on the expiry cycle still counts, so the kick takes priority over the tick.
  always_ff @(posedge clk_in or negedge b_reset) begin
    if (!b_reset) begin
      wdt_cnt   <= '1;
      wdt_en    <= 1'b0;
      wdt_fired <= 1'b0;
    end else if (wdt_fire) begin
      wdt_cnt   <= '1;
      wdt_en    <= 1'b0;
      wdt_fired <= 1'b1;
    end else begin
      if (wdt_kick) begin
        wdt_cnt <= '1;
      end else if (wdt_tick) begin
        wdt_cnt <= wdt_cnt - 1'b1;
      end
      if (wdt_wr && !wdt_kick) begin
        wdt_en <= DI[0];
      end
    end
  end
`else
  assign wdt_fire = 1'b0;
  assign wdt_rd   = 8'hFF;
`endif

  always_comb begin
    DO = 8'hFF;
    case (AD)
      3'd0: begin
        DO = 8'h00;
        DO[NIRQ-1:0] = pend;
      end
      3'd1: begin
        DO = 8'h00;
        DO[NIRQ-1:0] = mask;
      end
      3'd2: begin
        DO = 8'h00;
        DO[NIRQ-1:0] = mode;
      end
      3'd3: begin
        DO = 8'h00;
        DO[NIRQ-1:0] = irq_in;
      end
      3'd4: DO = wdt_rd;
      default: DO = 8'hFF;
    endcase
  end

endmodule
